// File: rtl/mem_access_unit.sv
// mem_access_unit: sequential load/store unit between the MIPS core and an
// Avalon-style bus. Handles byte-lane placement, byteenable generation,
// optional big-endian byte reversal, waitrequest stalls and load extension.
// Optional feature macro: MEM_ACCESS_TIMEOUT_EN (abort a stalled access
// after TIMEOUT_CYCLES consecutive waitrequest cycles).
module mem_access_unit #(
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned ADDR_WIDTH     = 32,
   parameter int unsigned ENDIAN_SWAP    = 1,
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      req_valid,
   output logic                      req_ready,
   input  logic                      req_write,
   input  logic [1:0]                req_size,
   input  logic                      req_signed,
   input  logic [ADDR_WIDTH-1:0]     req_addr,
   input  logic [DATA_WIDTH-1:0]     req_wdata,
   output logic                      resp_valid,
   output logic [DATA_WIDTH-1:0]     resp_rdata,
   output logic                      resp_fault,
   output logic [ADDR_WIDTH-1:0]     address,
   output logic                      read,
   output logic                      write,
   input  logic                      waitrequest,
   output logic [DATA_WIDTH-1:0]     writedata,
   output logic [DATA_WIDTH/8-1:0]   byteenable,
   input  logic [DATA_WIDTH-1:0]     readdata
);

   localparam int unsigned NB  = DATA_WIDTH / 8;
   localparam int unsigned OFS = $clog2(NB);

   // Elaboration-time parameter sanity checks
   if (DATA_WIDTH < 32 || (DATA_WIDTH & (DATA_WIDTH - 1)) != 0) begin : g_bad_dw
      $error("DATA_WIDTH must be a power of two >= 32");
   end
   if (TIMEOUT_CYCLES < 1) begin : g_bad_tmo
      $error("TIMEOUT_CYCLES must be >= 1");
   end

   typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

   // Number of bytes moved by an access of the given size code
   function automatic int unsigned size_bytes(input logic [1:0] sz);
      case (sz)
         2'b00:   return 1;
         2'b01:   return 2;
         default: return NB;
      endcase
   endfunction

   // Bus lane holding register byte k of an s-byte access at offset o
   function automatic logic [OFS-1:0] lane_of(input logic [OFS-1:0] o,
                                              input int unsigned s,
                                              input int unsigned k);
      if (ENDIAN_SWAP != 0) return OFS'(32'(o) + s - 1 - k);
      else                  return OFS'(32'(o) + k);
   endfunction

   // Spread right-justified store data onto its bus lanes; unused lanes zero
   function automatic logic [DATA_WIDTH-1:0] place(input logic [DATA_WIDTH-1:0] w,
                                                   input logic [OFS-1:0] o,
                                                   input logic [1:0] sz);
      logic [DATA_WIDTH-1:0] r;
      int unsigned s;
      r = '0;
      s = size_bytes(sz);
      for (int unsigned k = 0; k < NB; k++)
         if (k < s) r[8*lane_of(o, s, k) +: 8] = w[8*k +: 8];
      return r;
   endfunction

   // Active byte lanes for the access
   function automatic logic [NB-1:0] lanes(input logic [OFS-1:0] o,
                                           input logic [1:0] sz);
      logic [NB-1:0] r;
      int unsigned s;
      r = '0;
      s = size_bytes(sz);
      for (int unsigned k = 0; k < NB; k++)
         if (k < s) r[lane_of(o, s, k)] = 1'b1;
      return r;
   endfunction

   // Collect load bytes from their lanes, right-justify and extend
   function automatic logic [DATA_WIDTH-1:0] gather(input logic [DATA_WIDTH-1:0] d,
                                                    input logic [OFS-1:0] o,
                                                    input logic [1:0] sz,
                                                    input logic sgn);
      logic [DATA_WIDTH-1:0] r;
      int unsigned s;
      logic msb;
      r = '0;
      s = size_bytes(sz);
      for (int unsigned k = 0; k < NB; k++)
         if (k < s) r[8*k +: 8] = d[8*lane_of(o, s, k) +: 8];
      msb = r[8*s-1];
      for (int unsigned i = 0; i < DATA_WIDTH; i++)
         if (i >= 8*s) r[i] = sgn & msb;
      return r;
   endfunction

   state_t                  state_q;
   logic                    req_ready_q, resp_valid_q, resp_fault_q;
   logic [DATA_WIDTH-1:0]   resp_rdata_q;
   logic [ADDR_WIDTH-1:0]   address_q;
   logic                    read_q, write_q;
   logic [DATA_WIDTH-1:0]   wdata_q;
   logic [NB-1:0]           be_q;
   logic                    wr_q, sgn_q;
   logic [1:0]              size_q;
   logic [OFS-1:0]          ofs_q;

   logic [OFS-1:0]          ofs_d;
   logic                    illegal_d;
   logic [NB-1:0]           be_d;
   logic [DATA_WIDTH-1:0]   wdata_d;
   logic [DATA_WIDTH-1:0]   rdata_d;

   // Request decode and lane-mapped data paths
   always_comb begin
      ofs_d     = req_addr[OFS-1:0];
      illegal_d = (req_size == 2'b11) ||
                  (req_size == 2'b01 && ofs_d[0]) ||
                  (req_size == 2'b10 && ofs_d != '0);
      be_d      = lanes(ofs_d, req_size);
      wdata_d   = req_write ? place(req_wdata, ofs_d, req_size) : '0;
      rdata_d   = gather(readdata, ofs_q, size_q, sgn_q);
   end

`ifdef MEM_ACCESS_TIMEOUT_EN
   localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0] tmo_q;
`endif

   // Control FSM with registered bus and response outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= S_IDLE;
         req_ready_q  <= 1'b1;
         resp_valid_q <= 1'b0;
         resp_fault_q <= 1'b0;
         resp_rdata_q <= '0;
         address_q    <= '0;
         read_q       <= 1'b0;
         write_q      <= 1'b0;
         wdata_q      <= '0;
         be_q         <= '0;
         wr_q         <= 1'b0;
         sgn_q        <= 1'b0;
         size_q       <= 2'b00;
         ofs_q        <= '0;
`ifdef MEM_ACCESS_TIMEOUT_EN
         tmo_q        <= '0;
`endif
      end else begin
         resp_valid_q <= 1'b0;
         resp_fault_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (req_valid) begin
                  wr_q         <= req_write;
                  size_q       <= req_size;
                  sgn_q        <= req_signed;
                  ofs_q        <= ofs_d;
                  req_ready_q  <= 1'b0;
                  resp_rdata_q <= '0;
                  if (illegal_d) begin
                     state_q      <= S_RESP;
                     resp_valid_q <= 1'b1;
                     resp_fault_q <= 1'b1;
                  end else begin
                     state_q   <= S_ACCESS;
                     address_q <= {req_addr[ADDR_WIDTH-1:OFS], OFS'(0)};
                     read_q    <= ~req_write;
                     write_q   <= req_write;
                     be_q      <= be_d;
                     wdata_q   <= wdata_d;
                  end
               end
            end
            S_ACCESS: begin
               if (!waitrequest) begin
                  state_q      <= S_RESP;
                  read_q       <= 1'b0;
                  write_q      <= 1'b0;
                  resp_valid_q <= 1'b1;
                  resp_rdata_q <= wr_q ? '0 : rdata_d;
`ifdef MEM_ACCESS_TIMEOUT_EN
                  tmo_q        <= '0;
               end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
                  state_q      <= S_RESP;
                  read_q       <= 1'b0;
                  write_q      <= 1'b0;
                  resp_valid_q <= 1'b1;
                  resp_fault_q <= 1'b1;
                  resp_rdata_q <= '0;
                  tmo_q        <= '0;
               end else begin
                  tmo_q <= tmo_q + TW'(1);
`endif
               end
            end
            S_RESP: begin
               state_q     <= S_IDLE;
               req_ready_q <= 1'b1;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign req_ready  = req_ready_q;
   assign resp_valid = resp_valid_q;
   assign resp_fault = resp_fault_q;
   assign resp_rdata = resp_rdata_q;
   assign address    = address_q;
   assign read       = read_q;
   assign write      = write_q;
   assign writedata  = wdata_q;
   assign byteenable = be_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit (32-bit bus, big-endian core).
module tb_mem_access_unit;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_write = 1'b0;
   logic [1:0]  req_size = 2'b00;
   logic        req_signed = 1'b0;
   logic [31:0] req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_fault;
   logic [31:0] address;
   logic        read;
   logic        write;
   logic        waitrequest = 1'b0;
   logic [31:0] writedata;
   logic [3:0]  byteenable;
   logic [31:0] readdata = '0;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   mem_access_unit #(
      .DATA_WIDTH(32), .ADDR_WIDTH(32), .ENDIAN_SWAP(1), .TIMEOUT_CYCLES(16)
   ) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
      .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
      .resp_fault(resp_fault), .address(address), .read(read), .write(write),
      .waitrequest(waitrequest), .writedata(writedata), .byteenable(byteenable),
      .readdata(readdata)
   );

   typedef struct {
      string       name;
      logic        wr;
      logic [1:0]  sz;
      logic        sgn;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      logic        fault;
      logic [31:0] exp_addr;
      logic [3:0]  exp_be;
      logic [31:0] exp_wd;
      logic [31:0] exp_rd;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive_req(input logic wr, input logic [1:0] sz, input logic sgn,
                            input logic [31:0] addr, input logic [31:0] wd);
      req_valid  = 1'b1;
      req_write  = wr;
      req_size   = sz;
      req_signed = sgn;
      req_addr   = addr;
      req_wdata  = wd;
   endtask

   task automatic run_vec(input vec_t v);
      @(negedge clk);
      drive_req(v.wr, v.sz, v.sgn, v.addr, v.wdata);
      readdata    = v.rdata;
      waitrequest = 1'b0;
      @(posedge clk); #1;
      req_valid = 1'b0;
      chk({v.name, ".ready_busy"}, 32'(req_ready), 32'd0);
      if (v.fault) begin
         chk({v.name, ".resp_valid"}, 32'(resp_valid), 32'd1);
         chk({v.name, ".fault"},      32'(resp_fault), 32'd1);
         chk({v.name, ".strobes"},    32'({read, write}), 32'd0);
         chk({v.name, ".rdata"},      resp_rdata, 32'd0);
      end else begin
         chk({v.name, ".strobes"},    32'({read, write}), v.wr ? 32'd1 : 32'd2);
         chk({v.name, ".address"},    address, v.exp_addr);
         chk({v.name, ".be"},         32'(byteenable), 32'(v.exp_be));
         chk({v.name, ".writedata"},  writedata, v.exp_wd);
         chk({v.name, ".early_resp"}, 32'(resp_valid), 32'd0);
         @(posedge clk); #1;
         chk({v.name, ".resp_valid"}, 32'(resp_valid), 32'd1);
         chk({v.name, ".fault"},      32'(resp_fault), 32'd0);
         chk({v.name, ".rdata"},      resp_rdata, v.exp_rd);
         chk({v.name, ".strobes_off"},32'({read, write}), 32'd0);
      end
      @(posedge clk); #1;
      chk({v.name, ".resp_pulse"}, 32'(resp_valid), 32'd0);
      chk({v.name, ".ready_back"}, 32'(req_ready), 32'd1);
   endtask

   initial begin
      int n;
      //          name        wr    sz     sgn   addr          wdata          rdata          flt   addr      be       wd             rd
      vecs.push_back('{"st_word",  1'b1, 2'b10, 1'b0, 32'h100, 32'h11223344, 32'h0,        1'b0, 32'h100, 4'b1111, 32'h44332211, 32'h0});
      vecs.push_back('{"ld_sb",    1'b0, 2'b00, 1'b1, 32'h103, 32'h0,        32'h80000000, 1'b0, 32'h100, 4'b1000, 32'h0,        32'hFFFFFF80});
      vecs.push_back('{"ld_ub",    1'b0, 2'b00, 1'b0, 32'h103, 32'h0,        32'h80000000, 1'b0, 32'h100, 4'b1000, 32'h0,        32'h00000080});
      vecs.push_back('{"ld_uh",    1'b0, 2'b01, 1'b0, 32'h102, 32'h0,        32'hBBAA0000, 1'b0, 32'h100, 4'b1100, 32'h0,        32'h0000AABB});
      vecs.push_back('{"ld_sh",    1'b0, 2'b01, 1'b1, 32'h102, 32'h0,        32'h00800000, 1'b0, 32'h100, 4'b1100, 32'h0,        32'hFFFF8000});
      vecs.push_back('{"ld_sh_pos",1'b0, 2'b01, 1'b1, 32'h100, 32'h0,        32'h0000FF01, 1'b0, 32'h100, 4'b0011, 32'h0,        32'h000001FF});
      vecs.push_back('{"ld_word",  1'b0, 2'b10, 1'b1, 32'h200, 32'h0,        32'h11223344, 1'b0, 32'h200, 4'b1111, 32'h0,        32'h44332211});
      vecs.push_back('{"st_half",  1'b1, 2'b01, 1'b0, 32'h106, 32'hDEADBEEF, 32'h0,        1'b0, 32'h104, 4'b1100, 32'hEFBE0000, 32'h0});
      vecs.push_back('{"st_byte",  1'b1, 2'b00, 1'b0, 32'h001, 32'h12345678, 32'h0,        1'b0, 32'h000, 4'b0010, 32'h00007800, 32'h0});
      vecs.push_back('{"ld_sb_pos",1'b0, 2'b00, 1'b1, 32'h000, 32'h0,        32'h0000007F, 1'b0, 32'h000, 4'b0001, 32'h0,        32'h0000007F});
      vecs.push_back('{"f_word",   1'b0, 2'b10, 1'b0, 32'h101, 32'h0,        32'h0,        1'b1, 32'h0,   4'b0000, 32'h0,        32'h0});
      vecs.push_back('{"f_half",   1'b0, 2'b01, 1'b0, 32'h103, 32'h0,        32'h0,        1'b1, 32'h0,   4'b0000, 32'h0,        32'h0});
      vecs.push_back('{"f_size11", 1'b0, 2'b11, 1'b0, 32'h100, 32'h0,        32'h0,        1'b1, 32'h0,   4'b0000, 32'h0,        32'h0});
      vecs.push_back('{"f_st_word",1'b1, 2'b10, 1'b0, 32'h102, 32'h55667788, 32'h0,        1'b1, 32'h0,   4'b0000, 32'h0,        32'h0});

      // Reset state
      #12;
      chk("rst.ready",   32'(req_ready), 32'd1);
      chk("rst.strobes", 32'({read, write, resp_valid, resp_fault}), 32'd0);
      chk("rst.address", address, 32'd0);
      chk("rst.be",      32'(byteenable), 32'd0);
      chk("rst.wdata",   writedata, 32'd0);
      chk("rst.rdata",   resp_rdata, 32'd0);
      @(negedge clk);
      reset = 1'b0;

      foreach (vecs[i]) run_vec(vecs[i]);

      // Byte store stalled for 3 cycles; new requests ignored while busy
      @(negedge clk);
      drive_req(1'b1, 2'b00, 1'b0, 32'h101, 32'h000000AB);
      waitrequest = 1'b1;
      @(posedge clk);
      for (int i = 0; i < 4; i++) begin
         #1;
         if (i == 0) drive_req(1'b0, 2'b10, 1'b0, 32'h300, 32'h0);
         chk($sformatf("stall.write%0d", i), 32'(write), 32'd1);
         chk($sformatf("stall.addr%0d", i),  address, 32'h100);
         chk($sformatf("stall.be%0d", i),    32'(byteenable), 32'b0010);
         chk($sformatf("stall.wd%0d", i),    writedata, 32'h0000AB00);
         chk($sformatf("stall.ready%0d", i), 32'(req_ready), 32'd0);
         chk($sformatf("stall.resp%0d", i),  32'(resp_valid), 32'd0);
         if (i == 3) begin
            waitrequest = 1'b0;
            req_valid   = 1'b0;
         end
         @(posedge clk);
      end
      #1;
      chk("stall.resp_valid", 32'(resp_valid), 32'd1);
      chk("stall.fault",      32'(resp_fault), 32'd0);
      chk("stall.write_off",  32'(write), 32'd0);
      chk("stall.rdata",      resp_rdata, 32'd0);
      @(posedge clk); #1;
      chk("stall.ready_back", 32'(req_ready), 32'd1);

      // Reset in the middle of an access drops it silently
      @(negedge clk);
      drive_req(1'b1, 2'b00, 1'b0, 32'h104, 32'h5A);
      waitrequest = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      chk("mrst.write_on", 32'(write), 32'd1);
      @(negedge clk);
      reset = 1'b1;
      #1;
      chk("mrst.write_off", 32'(write), 32'd0);
      chk("mrst.resp",      32'(resp_valid), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      waitrequest = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         chk($sformatf("mrst.quiet%0d", i), 32'({resp_valid, read, write}), 32'd0);
         chk($sformatf("mrst.ready%0d", i), 32'(req_ready), 32'd1);
      end

      // Permanently stalled load: abort with timeout, or wait indefinitely
      @(negedge clk);
      drive_req(1'b0, 2'b00, 1'b1, 32'h100, 32'h0);
      waitrequest = 1'b1;
      readdata    = 32'h000000AB;
      @(posedge clk); #1;
      req_valid = 1'b0;
      n = 0;
      while (read && n < 40) begin
         n++;
         @(posedge clk); #1;
      end
`ifdef MEM_ACCESS_TIMEOUT_EN
      chk("tmo.read_cycles", 32'(n), 32'd16);
      chk("tmo.resp_valid",  32'(resp_valid), 32'd1);
      chk("tmo.fault",       32'(resp_fault), 32'd1);
      chk("tmo.rdata",       resp_rdata, 32'd0);
      @(posedge clk); #1;
      chk("tmo.ready_back",  32'(req_ready), 32'd1);
`else
      chk("stuck.read_cycles", 32'(n), 32'd40);
      chk("stuck.no_resp",     32'(resp_valid), 32'd0);
      waitrequest = 1'b0;
      @(posedge clk); #1;
      chk("stuck.resp_valid",  32'(resp_valid), 32'd1);
      chk("stuck.fault",       32'(resp_fault), 32'd0);
      chk("stuck.rdata",       resp_rdata, 32'hFFFFFFAB);
      @(posedge clk); #1;
      chk("stuck.ready_back",  32'(req_ready), 32'd1);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
Sequential load/store unit between the multicycle MIPS core and the Avalon-style memory bus. It accepts one load/store request at a time and aligns byte lanes. It generates byteenable, performs big-endian/bus byte-order conversion, and runs the waitrequest handshake. It returns sign- or zero-extended load data, or a fault for illegal requests, and replaces the purely combinational lane/endian select in the datapath.

Parameters:
DATA_WIDTH, 32, bus and register width in bits. Power of two, >=32. NB = DATA_WIDTH/8 byte lanes, OFS = log2(NB) offset bits.
ADDR_WIDTH, 32, byte-address width.
ENDIAN_SWAP, 1, 1 = core is big-endian over a little-lane bus (bytes reversed within each access); 0 = no reversal.
TIMEOUT_CYCLES, 16, maximum waitrequest cycles before abort. Used only with MEM_ACCESS_TIMEOUT_EN.

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high
req_valid  in  1  request present
req_ready  out  1  unit can accept request
req_write  in  1  1 = store, 0 = load
req_size  in  2  00 byte, 01 half, 10 word (NB bytes), 11 reserved
req_signed  in  1  sign-extend load result (ignored for word, stores)
req_addr  in  ADDR_WIDTH  byte address
req_wdata  in  DATA_WIDTH  store data, right-justified (rt)
resp_valid  out  1  one-cycle completion pulse
resp_rdata  out  DATA_WIDTH  extended load result, 0 for stores/faults
resp_fault  out  1  valid with resp_valid; misaligned/reserved/timeout
address  out  ADDR_WIDTH  word-aligned bus address (low OFS bits 0)
read  out  1  bus read strobe
write  out  1  bus write strobe
waitrequest  in  1  slave stall
writedata  out  DATA_WIDTH  lane-placed store data
byteenable  out  NB  active lanes
readdata  in  DATA_WIDTH  bus read data, valid in the cycle waitrequest=0 with read=1

Behaviour:
- Reset (async, any state): state=IDLE. req_ready=1 after reset deasserts. read=write=resp_valid=resp_fault=0. address, writedata, byteenable, resp_rdata = 0. An in-flight access is dropped with no response.
- States: IDLE, ACCESS, RESP.
- IDLE: req_ready=1. On req_valid, register all request fields, offset o = req_addr[OFS-1:0], lanes and placed write data.
  - Illegal request goes to RESP with fault=1; no bus cycle. Illegal = size 11, half with o[0]=1, or word with o!=0.
  - Otherwise go to ACCESS.
- ACCESS: req_ready=0. read or write=1. address, byteenable, writedata held stable while waitrequest=1.
  - When waitrequest=0, capture readdata (loads) and go to RESP. Strobes drop the following cycle.
- RESP: resp_valid=1 for exactly one cycle, then IDLE. No backpressure; the core must sample it. req_ready=0 in RESP.
- Minimum latency: accept edge -> ACCESS 1 cycle -> resp_valid on 2nd cycle after acceptance. Fault: resp_valid on 1st cycle.
- Lane mapping: byte offset i occupies writedata/readdata bits [8i+7:8i].
  - Byte: lane o, byteenable=1<<o.
  - Half: lanes o, o+1, byteenable=3<<o.
  - Word: all lanes, byteenable all ones.
- Endian (ENDIAN_SWAP=1): for an access of S bytes at offset o, register byte k (bits [8k+7:8k]) maps to lane o+S-1-k, for both store and load. With ENDIAN_SWAP=0, register byte k maps to lane o+k.
- Unused writedata lanes = 0.
- Load result: the S gathered bytes are right-justified. Upper bits are filled with bit 8S-1 if req_signed, else 0.
- Store response: resp_rdata=0, fault=0.
- req_valid in a non-IDLE state is ignored (not accepted).

Optional Feature:
MEM_ACCESS_TIMEOUT_EN: defined -> a saturating counter runs in ACCESS while waitrequest=1. On reaching TIMEOUT_CYCLES consecutive stalled cycles:
- drop read/write,
- go to RESP with resp_fault=1, resp_rdata=0,
- clear the counter on leaving ACCESS.
Undefined -> no counter; ACCESS waits on waitrequest indefinitely.

Test Plan:
All cases use DATA_WIDTH=32 and ENDIAN_SWAP=1.
- Store word: req_wdata=0x11223344, addr 0x100, waitrequest=0 -> address=0x100, write=1, byteenable=1111, writedata=0x44332211, resp_valid 2 cycles after accept, fault=0.
- Signed byte load: addr 0x103, readdata=0x80000000 -> byteenable=1000, resp_rdata=0xFFFFFF80. Same with req_signed=0 -> 0x00000080.
- Unsigned half load: addr 0x102, readdata=0xBBAA0000 -> byteenable=1100, resp_rdata=0x0000AABB. Signed with readdata=0x0080_0000 at addr 0x102 -> 0xFFFF8000.
- Misaligned word load: addr 0x101 -> read never asserted, resp_valid 1 cycle after accept with resp_fault=1. Half at 0x103 and size=11 behave the same.
- waitrequest=1 for 3 cycles on byte store at 0x101, wdata 0xAB -> address/byteenable=0010/writedata=0x0000AB00 stable all 4 ACCESS cycles, resp_valid 1 cycle after waitrequest falls. Reset asserted mid-ACCESS -> write=0 immediately, no resp_valid, req_ready=1 after release.
- MEM_ACCESS_TIMEOUT_EN defined, TIMEOUT_CYCLES=16, waitrequest stuck 1 -> read drops after 16 stalled cycles, resp_valid with resp_fault=1, req_ready=1 next cycle.
